systolic_ctrl: RTL and testbench
================================

Name: systolic_ctrl

Overview:
- Sequencer for an N x N weight-stationary systolic array of 8-bit PEs.
- Each PE has per-row load, i_weight, west/north inputs and registered east/south outputs.
- On start, loads one weight row per cycle from a weight memory, streams M activation vectors into the array's west edge with per-row skew, deskews the south-edge outputs, and returns one N-lane result vector per accepted activation vector.
- Sits between the layer scheduler (start/done) and the PE array.

Parameters:
- N, 4, array dimension (rows = columns = N), N >= 2.
- CNT_W, 16, width of the vector count.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a job when idle, ignored otherwise.
- num_vec  input  CNT_W  number of activation vectors M; sampled when start is accepted.
- busy  output  1  high from the cycle after start is accepted through the done cycle.
- done  output  1  one-cycle pulse at job end.
- w_rd_en  output  1  weight memory read strobe.
- w_rd_addr  output  $clog2(N)  weight row index.
- w_rd_data  input  8*N  weight row; valid the cycle after w_rd_en; lane c feeds column c.
- act_valid  input  1  activation vector valid.
- act_ready  output  1  controller accepts the vector this cycle.
- act_data  input  8*N  activation vector; lane k feeds row k.
- pe_load  output  N  per-row PE load; bit r drives load of every PE in row r.
- pe_weight  output  8*N  column weight bus; lane c drives i_weight of column c.
- pe_west  output  8*N  lane r drives i_west of PE(r,0).
- pe_south  input  8*N  o_south of bottom-row PE(N-1,c), lane c.
- res_valid  output  1  result vector valid, one cycle, no backpressure.
- res_data  output  8*N  lane c = sum over k of w[k][c]*a[k], mod 256.

Behaviour:
- Reset: state IDLE. busy, done, w_rd_en, act_ready, pe_load, res_valid = 0. w_rd_addr, pe_weight, pe_west, res_data = 0. Skew, deskew and valid-tag pipelines are cleared.
- A reset mid-job aborts the job with no done pulse. Array weights are then undefined until the next job reloads them.
- States: IDLE, WLOAD, STREAM, DRAIN, DONE.
- IDLE: on start, latch num_vec and go to WLOAD.
- WLOAD lasts N+1 cycles:
  - Cycle i (0..N-1): w_rd_en=1, w_rd_addr=i.
  - Cycle i+1: pe_load = one-hot(i), pe_weight = w_rd_data.
  - In the final cycle, go to STREAM if M>0, else to DONE.
  - pe_load is never high outside WLOAD.
  - pe_west = 0 throughout WLOAD.
- STREAM:
  - act_ready=1 until M vectors are accepted; a vector is accepted when act_valid&&act_ready.
  - Lane k of an accepted vector enters a k-deep skew register chain plus one output register, so row k's input is presented k cycles after row 0's.
  - Cycles without acceptance inject a zero slot with valid tag 0.
  - Valid tags travel in a shift register matching the datapath latency.
  - After the M-th accept, act_ready drops in the next cycle and the state becomes DRAIN.
- Deskew: pe_south lane c is delayed N-1-c cycles, then registered into res_data.
- Latency: a vector accepted in cycle T produces res_valid=1 in cycle T+2N+1, with res_data aligned across all lanes. Results appear in acceptance order; bubbles produce no res_valid.
- DRAIN: wait until the valid-tag pipeline is empty, i.e. the last result is emitted, then go to DONE.
- DONE: done=1 for one cycle, busy deasserts in the following cycle, return to IDLE.
- Arithmetic: the controller does no arithmetic. Widths are passed unchanged; 8-bit wrap happens in the PEs.
- Between results, res_data holds its last registered value (don't-care when res_valid=0).
- start is ignored while busy. A start coincident with the done cycle is also ignored.
- pe_west carries only skewed activations or zeros, never stale data after DRAIN.

Test Plan:
- N=4, identity weights, M=1, act=[1,2,3,4] -> pe_load sequences 0001,0010,0100,1000 over WLOAD cycles 1..4; res_valid exactly 9 cycles after accept; res_data lanes=[1,2,3,4]; done one cycle after DRAIN empties.
- N=4, all weights 2, M=3 back-to-back act=[1,1,1,1],[2,0,0,0],[100,100,0,0] -> results [8,8,8,8],[4,4,4,4],[144,144,144,144] (400 mod 256) in consecutive cycles.
- N=4, weights w[k][c]=k+1, M=2 with act_valid gaps of 3 cycles -> exactly 2 res_valid pulses, each 9 cycles after its accept; lanes all equal to the sum of (k+1)*a[k]; no spurious valids.
- num_vec=0 -> WLOAD runs N+1 cycles, act_ready never high, done pulses, no res_valid.
- Reset asserted during STREAM after 2 accepts -> next cycle all outputs 0, state IDLE, no done; a new start reloads weights and the job completes correctly.
- start pulsed while busy and in the done cycle -> ignored; busy/done timing unchanged, num_vec not re-sampled.

Source files
------------

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Brief    : Sequencer for an N x N weight-stationary systolic array of 8-bit
//            PEs. Loads weight rows, streams skewed activation vectors into
//            the west edge, deskews south-edge outputs and returns one result
//            vector per accepted activation vector.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   w_rd_en,
  output logic [$clog2(N)-1:0]   w_rd_addr,
  input  logic [8*N-1:0]         w_rd_data,
  input  logic                   act_valid,
  output logic                   act_ready,
  input  logic [8*N-1:0]         act_data,
  output logic [N-1:0]           pe_load,
  output logic [8*N-1:0]         pe_weight,
  output logic [8*N-1:0]         pe_west,
  input  logic [8*N-1:0]         pe_south,
  output logic                   res_valid,
  output logic [8*N-1:0]         res_data
);

  localparam int AW   = $clog2(N);
  localparam int CW   = $clog2(N + 1);
  // Accept-to-result latency is 2N+1: 2N tag stages plus the res_valid register.
  localparam int TAGL = 2 * N;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [CNT_W-1:0]  r_remain;
  logic              r_busy;
  logic              r_done;
  logic              r_w_rd_en;
  logic [AW-1:0]     r_w_rd_addr;
  logic              r_act_ready;
  logic [N-1:0]      r_pe_load;
  logic [TAGL-1:0]   r_tag;
  logic              r_res_valid;

  logic              w_accept;
  logic              w_res_load;

  assign w_accept   = act_valid & r_act_ready;
  assign w_res_load = r_tag[TAGL-1];

  assign busy      = r_busy;
  assign done      = r_done;
  assign w_rd_en   = r_w_rd_en;
  assign w_rd_addr = r_w_rd_addr;
  assign act_ready = r_act_ready;
  assign pe_load   = r_pe_load;
  assign res_valid = r_res_valid;

  // Read data arrives one cycle after the strobe, exactly when the matching
  // row load is high, so the weight bus is a gated pass-through.
  assign pe_weight = (|r_pe_load) ? w_rd_data : '0;

  // Job sequencer: weight load, streaming, drain and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_remain    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_w_rd_addr <= '0;
      r_act_ready <= 1'b0;
      r_pe_load   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_remain    <= num_vec;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_w_rd_en   <= 1'b1;
            r_w_rd_addr <= '0;
            r_state     <= S_WLOAD;
          end
        end
        S_WLOAD: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt < CW'(N - 1)) begin
            r_w_rd_en   <= 1'b1;
            r_w_rd_addr <= AW'(r_cnt + CW'(1));
          end else begin
            r_w_rd_en   <= 1'b0;
            r_w_rd_addr <= '0;
          end
          // Row r is written one cycle after its read strobe.
          if (r_cnt < CW'(N)) begin
            r_pe_load <= N'(1) << r_cnt;
          end else begin
            r_pe_load <= '0;
          end
          if (r_cnt == CW'(N)) begin
            if (r_remain != '0) begin
              r_act_ready <= 1'b1;
              r_state     <= S_STREAM;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            r_remain <= r_remain - CNT_W'(1);
            if (r_remain == CNT_W'(1)) begin
              r_act_ready <= 1'b0;
              r_state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Empty tag pipe means the final result is on res_valid now.
          if (r_tag == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Valid tags follow the datapath so bubbles never raise res_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_tag       <= {r_tag[TAGL-2:0], w_accept};
      r_res_valid <= r_tag[TAGL-1];
    end
  end

  // West-edge skew: lane k is delayed k cycles plus one output register.
  for (genvar k = 0; k < N; k++) begin : g_skew
    logic [7:0] w_lane;
    logic [7:0] r_out;
    assign w_lane = w_accept ? act_data[8*k +: 8] : 8'd0;

    if (k == 0) begin : g_direct
      // Row 0 sees the accepted lane after the output register only.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_out <= 8'd0;
        end else begin
          r_out <= w_lane;
        end
      end
    end else begin : g_chain
      logic [7:0] r_sk [k];
      // k-deep delay chain ahead of the output register.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < k; j++) begin
            r_sk[j] <= 8'd0;
          end
          r_out <= 8'd0;
        end else begin
          r_sk[0] <= w_lane;
          for (int j = 1; j < k; j++) begin
            r_sk[j] <= r_sk[j-1];
          end
          r_out <= r_sk[k-1];
        end
      end
    end

    assign pe_west[8*k +: 8] = r_out;
  end

  // South-edge deskew: lane c waits N-1-c cycles so all lanes line up.
  for (genvar c = 0; c < N; c++) begin : g_deskew
    localparam int D = N - 1 - c;
    logic [7:0] r_res;

    if (D == 0) begin : g_nodly
      // Last column is already aligned; capture on the result tag.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_res <= 8'd0;
        end else if (w_res_load) begin
          r_res <= pe_south[8*c +: 8];
        end
      end
    end else begin : g_dly
      logic [7:0] r_dl [D];
      // Delay line followed by a result register that holds between results.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < D; j++) begin
            r_dl[j] <= 8'd0;
          end
          r_res <= 8'd0;
        end else begin
          r_dl[0] <= pe_south[8*c +: 8];
          for (int j = 1; j < D; j++) begin
            r_dl[j] <= r_dl[j-1];
          end
          if (w_res_load) begin
            r_res <= r_dl[D-1];
          end
        end
      end
    end

    assign res_data[8*c +: 8] = r_res;
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Brief    : Directed self-checking bench for systolic_ctrl with a behavioural
//            4x4 weight-stationary PE array and a synchronous weight memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;

  localparam int N     = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             busy, done, w_rd_en, act_ready, res_valid;
  logic [1:0]       w_rd_addr;
  logic [31:0]      w_rd_data = '0;
  logic             act_valid = 1'b0;
  logic [31:0]      act_data = '0;
  logic [3:0]       pe_load;
  logic [31:0]      pe_weight, pe_west, pe_south, res_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_q[$];
  int res_q[$];
  int done_q[$];
  logic [31:0] resd_q[$];
  int rdy_cnt = 0;

  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .w_rd_data(w_rd_data), .act_valid(act_valid), .act_ready(act_ready),
    .act_data(act_data), .pe_load(pe_load), .pe_weight(pe_weight),
    .pe_west(pe_west), .pe_south(pe_south), .res_valid(res_valid),
    .res_data(res_data)
  );

  // Weight memory with one-cycle read latency.
  logic [7:0] wmem [N][N];
  always @(posedge clk) begin
    if (w_rd_en) for (int c = 0; c < N; c++) w_rd_data[8*c +: 8] <= wmem[w_rd_addr][c];
  end

  // Behavioural PE array: registered east/south, south = north + w*west.
  logic [7:0] pw [N][N];
  logic [7:0] pe_e [N][N];
  logic [7:0] pe_s [N][N];
  always @(posedge clk) begin : pe_model
    logic [7:0] wi, ni;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (reset) begin
          pw[r][c] <= 8'd0; pe_e[r][c] <= 8'd0; pe_s[r][c] <= 8'd0;
        end else begin
          if (c == 0) wi = pe_west[8*r +: 8]; else wi = pe_e[r][c-1];
          if (r == 0) ni = 8'd0; else ni = pe_s[r-1][c];
          pe_e[r][c] <= wi;
          pe_s[r][c] <= ni + pw[r][c] * wi;
          if (pe_load[r]) pw[r][c] <= pe_weight[8*c +: 8];
        end
      end
    end
  end
  always_comb for (int c = 0; c < N; c++) pe_south[8*c +: 8] = pe_s[N-1][c];

  // Event logs: accepts at the clock edge, outputs in mid-cycle.
  always @(posedge clk) begin
    if (act_valid && act_ready) acc_q.push_back(cyc);
    cyc <= cyc + 1;
  end
  always @(negedge clk) begin
    if (res_valid) begin res_q.push_back(cyc); resd_q.push_back(res_data); end
    if (done) done_q.push_back(cyc);
    if (act_ready) rdy_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic set_w(input int mode);
    for (int k = 0; k < N; k++)
      for (int c = 0; c < N; c++)
        wmem[k][c] = (mode == 0) ? ((k == c) ? 8'd1 : 8'd0) : (mode == 1) ? 8'd2 : 8'(k + 1);
  endtask

  task automatic clear_logs();
    acc_q.delete(); res_q.delete(); done_q.delete(); resd_q.delete(); rdy_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; act_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_job(input int m, output int s);
    start = 1'b1; num_vec = CNT_W'(m);
    @(negedge clk);
    start = 1'b0; num_vec = CNT_W'(7);
    s = cyc;
  endtask

  task automatic feed(input logic [31:0] v, input int gap, output bit ok);
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    act_valid = 1'b1; act_data = v;
    for (int i = 0; i < 50; i++) begin
      if (act_ready) begin @(negedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    act_valid = 1'b0; act_data = '0;
  endtask

  task automatic wait_idle(output int e, output bit ok);
    ok = 1'b0; e = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin ok = 1'b1; e = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, w_rd_en, act_ready, res_valid, pe_load, w_rd_addr} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 0", {busy, done, w_rd_en, act_ready, res_valid, pe_load, w_rd_addr});
    end
    n_chk++;
    if ({pe_weight, pe_west, res_data} !== 96'd0) begin
      n_fail++; $display("FAIL reset_data: got %h, expected 0", {pe_weight, pe_west, res_data});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_identity();
    int s, e; bit ok, ok2; logic [3:0] exp_ld;
    do_reset(); set_w(0); clear_logs();
    start_job(1, s);
    n_chk++;
    if ({busy, w_rd_en, w_rd_addr, pe_load} !== {1'b1, 1'b1, 2'd0, 4'd0}) begin
      n_fail++; $display("FAIL wload0: got %b, expected 11000000", {busy, w_rd_en, w_rd_addr, pe_load});
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      exp_ld = 4'b0001 << i;
      n_chk++;
      if (pe_load !== exp_ld) begin n_fail++; $display("FAIL pe_load%0d: got %b, expected %b", i, pe_load, exp_ld); end
      n_chk++;
      if (pe_weight !== (32'h1 << (8*i))) begin
        n_fail++; $display("FAIL pe_weight%0d: got %h, expected %h", i, pe_weight, 32'h1 << (8*i));
      end
      n_chk++;
      if (pe_west !== 32'd0 || w_rd_en !== (i < N-1)) begin
        n_fail++; $display("FAIL wload_side%0d: got west %h en %b, expected 0 / %b", i, pe_west, w_rd_en, (i < N-1));
      end
    end
    feed(32'h04030201, 0, ok);
    wait_idle(e, ok2);
    n_chk++;
    if (!(ok && ok2)) begin n_fail++; $display("FAIL id_timeout: got feed %b idle %b, expected 1 1", ok, ok2); end
    n_chk++;
    if (acc_q.size() != 1 || res_q.size() != 1 || done_q.size() != 1) begin
      n_fail++; $display("FAIL id_counts: got %0d/%0d/%0d, expected 1/1/1", acc_q.size(), res_q.size(), done_q.size());
    end else begin
      n_chk++;
      if (acc_q[0] != s + 5) begin n_fail++; $display("FAIL id_accept: got cycle %0d, expected %0d", acc_q[0], s + 5); end
      n_chk++;
      if (res_q[0] - acc_q[0] != 9) begin n_fail++; $display("FAIL id_latency: got %0d, expected 9", res_q[0] - acc_q[0]); end
      n_chk++;
      if (resd_q[0] !== 32'h04030201) begin n_fail++; $display("FAIL id_data: got %h, expected 04030201", resd_q[0]); end
      n_chk++;
      if (done_q[0] != res_q[0] + 1 || e != done_q[0] + 1) begin
        n_fail++; $display("FAIL id_done: got done %0d idle %0d, expected %0d %0d", done_q[0], e, res_q[0] + 1, res_q[0] + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s, e; bit ok, all_ok; logic [31:0] exp_d [3];
    exp_d[0] = 32'h08080808; exp_d[1] = 32'h04040404; exp_d[2] = 32'h90909090;
    do_reset(); set_w(1); clear_logs();
    start_job(3, s);
    all_ok = 1'b1;
    feed(32'h01010101, 0, ok); all_ok &= ok;
    feed(32'h00000002, 0, ok); all_ok &= ok;
    feed(32'h00006464, 0, ok); all_ok &= ok;
    wait_idle(e, ok); all_ok &= ok;
    n_chk++;
    if (!all_ok) begin n_fail++; $display("FAIL b2b_timeout: got 0, expected 1"); end
    n_chk++;
    if (acc_q.size() != 3 || res_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_counts: got %0d/%0d, expected 3/3", acc_q.size(), res_q.size());
    end else begin
      n_chk++;
      if (acc_q[2] - acc_q[0] != 2 || res_q[2] - res_q[0] != 2) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d/%0d, expected 2/2", acc_q[2] - acc_q[0], res_q[2] - res_q[0]);
      end
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (res_q[i] - acc_q[i] != 9 || resd_q[i] !== exp_d[i]) begin
          n_fail++; $display("FAIL b2b_res%0d: got lat %0d data %h, expected 9 %h", i, res_q[i] - acc_q[i], resd_q[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int s, e; bit ok, all_ok;
    do_reset(); set_w(2); clear_logs();
    start_job(2, s);
    all_ok = 1'b1;
    feed(32'h04030201, 0, ok); all_ok &= ok;
    feed(32'h281E140A, 3, ok); all_ok &= ok;
    wait_idle(e, ok); all_ok &= ok;
    n_chk++;
    if (!all_ok) begin n_fail++; $display("FAIL gap_timeout: got 0, expected 1"); end
    n_chk++;
    if (acc_q.size() != 2 || res_q.size() != 2) begin
      n_fail++; $display("FAIL gap_counts: got %0d/%0d, expected 2/2", acc_q.size(), res_q.size());
    end else begin
      n_chk++;
      if (acc_q[1] - acc_q[0] != 4) begin n_fail++; $display("FAIL gap_accepts: got %0d, expected 4", acc_q[1] - acc_q[0]); end
      n_chk++;
      if (res_q[0] - acc_q[0] != 9 || resd_q[0] !== 32'h1E1E1E1E) begin
        n_fail++; $display("FAIL gap_res0: got lat %0d data %h, expected 9 1e1e1e1e", res_q[0] - acc_q[0], resd_q[0]);
      end
      n_chk++;
      if (res_q[1] - acc_q[1] != 9 || resd_q[1] !== 32'h2C2C2C2C) begin
        n_fail++; $display("FAIL gap_res1: got lat %0d data %h, expected 9 2c2c2c2c", res_q[1] - acc_q[1], resd_q[1]);
      end
    end
  endtask

  task automatic test_zero();
    int s, e; bit ok;
    do_reset(); set_w(0); clear_logs();
    start_job(0, s);
    wait_idle(e, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL zero_timeout: got busy 1, expected 0"); end
    n_chk++;
    if (done_q.size() != 1 || e != s + 6) begin
      n_fail++; $display("FAIL zero_done: got %0d pulses idle at %0d, expected 1 at %0d", done_q.size(), e, s + 6);
    end else begin
      n_chk++;
      if (done_q[0] != s + 5) begin n_fail++; $display("FAIL zero_done_cyc: got %0d, expected %0d", done_q[0], s + 5); end
    end
    n_chk++;
    if (rdy_cnt != 0 || res_q.size() != 0) begin
      n_fail++; $display("FAIL zero_stream: got ready %0d results %0d, expected 0 0", rdy_cnt, res_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int s, e; bit ok, all_ok;
    do_reset(); set_w(0); clear_logs();
    start_job(4, s);
    all_ok = 1'b1;
    feed(32'h04030201, 0, ok); all_ok &= ok;
    feed(32'h11223344, 0, ok); all_ok &= ok;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, done, w_rd_en, act_ready, res_valid, pe_load, w_rd_addr} !== 11'd0) begin
      n_fail++; $display("FAIL mid_ctrl: got %b, expected 0", {busy, done, w_rd_en, act_ready, res_valid, pe_load, w_rd_addr});
    end
    n_chk++;
    if ({pe_weight, pe_west, res_data} !== 96'd0) begin
      n_fail++; $display("FAIL mid_data: got %h, expected 0", {pe_weight, pe_west, res_data});
    end
    reset = 1'b0;
    repeat (12) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done_q.size() != 0 || res_q.size() != 0) begin
      n_fail++; $display("FAIL mid_abort: got busy %b done %0d res %0d, expected 0 0 0", busy, done_q.size(), res_q.size());
    end
    set_w(2); clear_logs();
    start_job(1, s);
    feed(32'h04030201, 0, ok); all_ok &= ok;
    wait_idle(e, ok); all_ok &= ok;
    n_chk++;
    if (!all_ok) begin n_fail++; $display("FAIL mid_timeout: got 0, expected 1"); end
    n_chk++;
    if (res_q.size() != 1 || acc_q.size() != 1 || done_q.size() != 1) begin
      n_fail++; $display("FAIL mid_counts: got %0d/%0d/%0d, expected 1/1/1", res_q.size(), acc_q.size(), done_q.size());
    end else begin
      n_chk++;
      if (res_q[0] - acc_q[0] != 9 || resd_q[0] !== 32'h1E1E1E1E) begin
        n_fail++; $display("FAIL mid_rerun: got lat %0d data %h, expected 9 1e1e1e1e", res_q[0] - acc_q[0], resd_q[0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int s, a; bit ok;
    do_reset(); set_w(1); clear_logs();
    start_job(1, s);
    start = 1'b1; num_vec = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    feed(32'h01010101, 0, ok);
    a = cyc - 1;
    repeat (9) @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ign_done: got done %b busy %b at %0d, expected 1 1", done, busy, cyc);
    end
    start = 1'b1; num_vec = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_drop: got %b, expected 0", busy); end
    repeat (10) @(negedge clk);
    n_chk++;
    if (!ok || busy !== 1'b0 || acc_q.size() != 1 || res_q.size() != 1 || done_q.size() != 1) begin
      n_fail++; $display("FAIL ign_counts: got ok %b busy %b acc %0d res %0d done %0d, expected 1 0 1 1 1",
                         ok, busy, acc_q.size(), res_q.size(), done_q.size());
    end else begin
      n_chk++;
      if (acc_q[0] != s + 5 || acc_q[0] != a || done_q[0] != a + 10 || resd_q[0] !== 32'h08080808) begin
        n_fail++; $display("FAIL ign_timing: got acc %0d done %0d data %h, expected %0d %0d 08080808",
                           acc_q[0], done_q[0], resd_q[0], s + 5, s + 15);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_gaps();
    test_zero();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
